instrumented_adder_meter: RTL and testbench

//  Parametrised ring-oscillator delay meter around a WIDTH-bit adder under test.

---
 rtl/iam_pkg.sv | 22 ++
 rtl/instrumented_adder_core.sv | 64 ++++++
 rtl/instrumented_adder_meter.sv | 184 ++++++++++++++++++
 tb/tb_instrumented_adder_meter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/iam_pkg.sv
// rtl/iam_pkg.sv - shared types and constants for the instrumented adder meter
package iam_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } iam_state_e;

  localparam logic [2:0] ADDR_A      = 3'd0;
  localparam logic [2:0] ADDR_B      = 3'd1;
  localparam logic [2:0] ADDR_RING   = 3'd2;
  localparam logic [2:0] ADDR_EXT    = 3'd3;
  localparam logic [2:0] ADDR_SOUT   = 3'd4;
  localparam logic [2:0] ADDR_GATE   = 3'd5;
  localparam logic [2:0] ADDR_COUNT  = 3'd6;
  localparam logic [2:0] ADDR_SUM    = 3'd7;

  localparam logic [31:0] MASK_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/instrumented_adder_core.sv
// rtl/instrumented_adder_core.sv - sklansky adder with ring-select input mux and parity tap
// Purely combinational; CLOSE_RING=1 closes the oscillator loop internally.
module instrumented_adder_core #(
  parameter int WIDTH      = 32,
  parameter bit CLOSE_RING = 1'b1
) (
  input  logic [WIDTH-1:0] a_input,
  input  logic [WIDTH-1:0] b_input,
  input  logic [WIDTH-1:0] ring_mask_b,
  input  logic [WIDTH-1:0] ext_mask_b,
  input  logic [WIDTH-1:0] s_out_mask_b,
  input  logic             ring_en,
  input  logic             chain_in,
  output logic [WIDTH-1:0] sum,
  output logic             chain_out
);

  localparam int LEVELS = $clog2(WIDTH);

  logic             ring_fb;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] carry;

  // Group-generate across [i:0] via Sklansky prefix tree.
  function automatic logic [WIDTH-1:0] prefix_carry(input logic [WIDTH-1:0] g_in,
                                                    input logic [WIDTH-1:0] p_in);
    logic [WIDTH-1:0] g, p, g_nx, p_nx;
    g = g_in;
    p = p_in;
    for (int l = 0; l < LEVELS; l++) begin
      g_nx = g;
      p_nx = p;
      for (int i = 0; i < WIDTH; i++) begin
        if (((i >> l) & 1) == 1) begin
          g_nx[i] = g[i] | (p[i] & g[((i >> l) << l) - 1]);
          p_nx[i] = p[i] & p[((i >> l) << l) - 1];
        end
      end
      g = g_nx;
      p = p_nx;
    end
    return g;
  endfunction

  generate
    if (CLOSE_RING) begin : g_loop
      assign ring_fb = chain_out;
    end else begin : g_ext
      assign ring_fb = chain_in;
    end
  endgenerate

  always_comb begin
    a_eff = '0;
    for (int i = 0; i < WIDTH; i++) begin
      a_eff[i] = !ring_mask_b[i] ? ring_fb : (!ext_mask_b[i] ? 1'b0 : a_input[i]);
    end
  end

  assign carry     = prefix_carry(a_eff & b_input, a_eff ^ b_input);
  assign sum       = (a_eff ^ b_input) ^ {carry[WIDTH-2:0], 1'b0};
  assign chain_out = ring_en & ~^(sum & ~s_out_mask_b);

endmodule

// File: rtl/instrumented_adder_meter.sv
// rtl/instrumented_adder_meter.sv - ring-oscillator delay meter around an adder under test
// RING_MODEL=1 feeds the ring from a divide-by-3 toggle source; 0 closes it through the adder.
module instrumented_adder_meter
  import iam_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int GATE_W      = 24,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter bit RING_MODEL  = 1'b1
) (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic        active,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  input  logic        start,
  output logic        busy,
  output logic        done
);

  logic [WIDTH-1:0]       a_input, b_input, ring_mask_b, ext_mask_b, s_out_mask_b;
  logic [WIDTH-1:0]       sum, sum_capture;
  logic [GATE_W-1:0]      gate_cycles, timer;
  logic [CNT_W-1:0]       count;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [31:0]            rdata_mux;
  iam_state_e             state, state_next;
  logic                   ring_en, core_chain, model_chain, chain_src;
  logic                   sync_prev, rise, start_ok, cfg_wr, settle_end, run_end;

  assign busy       = (state != IDLE);
  assign start_ok   = start && active && (state == IDLE);
  assign cfg_wr     = cfg_we && !busy;
  assign settle_end = (timer == GATE_W'(SYNC_STAGES));
  assign run_end    = (timer == gate_cycles - GATE_W'(1));

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      a_input      <= '0;
      b_input      <= '0;
      ring_mask_b  <= MASK_RESET[WIDTH-1:0];
      ext_mask_b   <= MASK_RESET[WIDTH-1:0];
      s_out_mask_b <= MASK_RESET[WIDTH-1:0];
      gate_cycles  <= '0;
    end else if (cfg_wr) begin
      case (cfg_addr)
        ADDR_A:    a_input      <= cfg_wdata[WIDTH-1:0];
        ADDR_B:    b_input      <= cfg_wdata[WIDTH-1:0];
        ADDR_RING: ring_mask_b  <= cfg_wdata[WIDTH-1:0];
        ADDR_EXT:  ext_mask_b   <= cfg_wdata[WIDTH-1:0];
        ADDR_SOUT: s_out_mask_b <= cfg_wdata[WIDTH-1:0];
        ADDR_GATE: gate_cycles  <= cfg_wdata[GATE_W-1:0];
        default: ;
      endcase
    end
  end

  instrumented_adder_core #(
    .WIDTH      (WIDTH),
    .CLOSE_RING (!RING_MODEL)
  ) u_core (
    .a_input      (a_input),
    .b_input      (b_input),
    .ring_mask_b  (ring_mask_b),
    .ext_mask_b   (ext_mask_b),
    .s_out_mask_b (s_out_mask_b),
    .ring_en      (ring_en),
    .chain_in     (model_chain),
    .sum          (sum),
    .chain_out    (core_chain)
  );

  generate
    if (RING_MODEL) begin : g_model
      logic [1:0] phase;
      logic       tog;
      always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
          phase <= '0;
          tog   <= 1'b0;
        end else if (!ring_en) begin
          phase <= '0;
          tog   <= 1'b0;
        end else if (phase == 2'd2) begin
          phase <= '0;
          tog   <= ~tog;
        end else begin
          phase <= phase + 2'd1;
        end
      end
      assign model_chain = tog;
    end else begin : g_ring
      assign model_chain = 1'b0;
    end
  endgenerate

  assign chain_src = RING_MODEL ? model_chain : core_chain;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], chain_src};
      sync_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~sync_prev;

  // Timer restarts on every state change: counts SETTLE cycles, then RUN cycles.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (state != state_next) begin
      timer <= '0;
    end else if (state == SETTLE || state == RUN) begin
      timer <= timer + GATE_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (start_ok) begin
      count <= '0;
    end else if (state == RUN && active && rise && !(&count)) begin
      count <= count + CNT_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sum_capture <= '0;
    end else if (state_next == DONE && state != DONE) begin
      sum_capture <= sum & ~s_out_mask_b;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!active) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = SETTLE;
        SETTLE:  if (settle_end) state_next = (gate_cycles == '0) ? DONE : RUN;
        RUN:     if (run_end) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    ring_en = active && (state == SETTLE || state == RUN);
    done    = active && (state == DONE);
  end

  always_comb begin
    rdata_mux = '0;
    case (cfg_addr)
      ADDR_A:     rdata_mux = 32'(a_input);
      ADDR_B:     rdata_mux = 32'(b_input);
      ADDR_RING:  rdata_mux = 32'(ring_mask_b);
      ADDR_EXT:   rdata_mux = 32'(ext_mask_b);
      ADDR_SOUT:  rdata_mux = 32'(s_out_mask_b);
      ADDR_GATE:  rdata_mux = 32'(gate_cycles);
      ADDR_COUNT: rdata_mux = 32'(count);
      ADDR_SUM:   rdata_mux = 32'(sum_capture);
      default:    rdata_mux = '0;
    endcase
    cfg_rdata = active ? rdata_mux : 32'd0;
  end

endmodule

// File: tb/tb_instrumented_adder_meter.sv
// tb/tb_instrumented_adder_meter.sv - self-checking bench for instrumented_adder_meter
module tb_instrumented_adder_meter;
  import iam_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        active = 1'b1;
  logic        cfg_we = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  cfg_addr = 3'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic [31:0] rdata, rdata_s;
  logic        busy, busy_s, done, done_s;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          gate;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] smask;
    int          exp_count;
  } vec_t;

  typedef struct {
    int          latency;
    int          count;
    logic [31:0] sum;
  } exp_t;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] exp;
  } rd_t;

  exp_t sb[$];
  vec_t vecs[5];
  rd_t  rst_tab[8];

  instrumented_adder_meter dut (
    .wb_clk_i (clk), .rst_n (rst_n), .active (active), .cfg_we (cfg_we),
    .cfg_addr (cfg_addr), .cfg_wdata (cfg_wdata), .cfg_rdata (rdata),
    .start (start), .busy (busy), .done (done)
  );

  instrumented_adder_meter #(.CNT_W(4)) dut_sat (
    .wb_clk_i (clk), .rst_n (rst_n), .active (active), .cfg_we (cfg_we),
    .cfg_addr (cfg_addr), .cfg_wdata (cfg_wdata), .cfg_rdata (rdata_s),
    .start (start), .busy (busy_s), .done (done_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [31:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [2:0] addr, output logic [31:0] d, output logic [31:0] ds);
    cfg_addr = addr;
    #1;
    d  = rdata;
    ds = rdata_s;
  endtask

  // Cycle 1 is the one carrying start; returns the cycle number in which done is seen.
  task automatic start_and_wait(input bit gate_with_start, input logic [31:0] gate, output int lat);
    start = 1'b1;
    if (gate_with_start) begin
      cfg_we = 1'b1; cfg_addr = ADDR_GATE; cfg_wdata = gate;
    end
    tick();
    start = 1'b0; cfg_we = 1'b0;
    lat = 2;
    while (!done && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    logic [31:0] d, ds;
    exp_t        e;
    int          lat;
    bit          done_seen;

    vecs[0] = '{30, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5};
    vecs[1] = '{0,  32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 0};
    vecs[2] = '{12, 32'h0F0F_0F0F, 32'h0101_0101, 32'hFFFF_0000, 2};
    vecs[3] = '{18, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 3};
    vecs[4] = '{6,  32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_FFFF, 1};

    rst_tab[0] = '{ADDR_A,     32'h0};
    rst_tab[1] = '{ADDR_B,     32'h0};
    rst_tab[2] = '{ADDR_RING,  32'hFFFF_FFFF};
    rst_tab[3] = '{ADDR_EXT,   32'hFFFF_FFFF};
    rst_tab[4] = '{ADDR_SOUT,  32'hFFFF_FFFF};
    rst_tab[5] = '{ADDR_GATE,  32'h0};
    rst_tab[6] = '{ADDR_COUNT, 32'h0};
    rst_tab[7] = '{ADDR_SUM,   32'h0};

    repeat (3) tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();
    foreach (rst_tab[i]) begin
      cfg_read(rst_tab[i].addr, d, ds);
      check($sformatf("reset_reg%0d", rst_tab[i].addr), d, rst_tab[i].exp);
    end

    foreach (vecs[i]) begin
      cfg_write(ADDR_A, vecs[i].a);
      cfg_write(ADDR_B, vecs[i].b);
      cfg_write(ADDR_SOUT, vecs[i].smask);
      if (i != 2) cfg_write(ADDR_GATE, 32'(vecs[i].gate));
      e.latency = vecs[i].gate + 5;
      e.count   = vecs[i].exp_count;
      e.sum     = (vecs[i].a + vecs[i].b) & ~vecs[i].smask;
      sb.push_back(e);
      start_and_wait(i == 2, 32'(vecs[i].gate), lat);
      e = sb.pop_front();
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(e.latency));
      check($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd1);
      tick();
      check($sformatf("v%0d_busy_after", i), 32'(busy), 32'd0);
      check($sformatf("v%0d_done_after", i), 32'(done), 32'd0);
      cfg_read(ADDR_COUNT, d, ds);
      check($sformatf("v%0d_count", i), d, 32'(e.count));
      cfg_read(ADDR_SUM, d, ds);
      check($sformatf("v%0d_sum", i), d, e.sum);
    end

    cfg_write(ADDR_GATE, 32'd200);
    start_and_wait(1'b0, 32'd0, lat);
    check("sat_latency", 32'(lat), 32'd205);
    tick();
    cfg_read(ADDR_COUNT, d, ds);
    check("sat_count_wide", d, 32'd33);
    check("sat_count_4bit", ds, 32'd15);

    cfg_write(ADDR_A, 32'h33);
    cfg_write(ADDR_GATE, 32'd30);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 2;
    for (int j = 0; j < 8; j++) begin tick(); lat++; end
    cfg_we = 1'b1; cfg_addr = ADDR_A; cfg_wdata = 32'h55; start = 1'b1;
    tick(); lat++;
    cfg_we = 1'b0; start = 1'b0;
    tick(); lat++;
    start = 1'b1;
    tick(); lat++;
    start = 1'b0;
    while (!done && lat < 400) begin tick(); lat++; end
    check("busy_ignore_latency", 32'(lat), 32'd35);
    tick();
    cfg_read(ADDR_COUNT, d, ds);
    check("busy_ignore_count", d, 32'd5);
    cfg_read(ADDR_A, d, ds);
    check("busy_ignore_a_input", d, 32'h33);

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 9; j++) tick();
    active = 1'b0;
    tick();
    check("inactive_busy", 32'(busy), 32'd0);
    check("inactive_done", 32'(done), 32'd0);
    cfg_read(ADDR_RING, d, ds);
    check("inactive_rdata", d, 32'd0);
    done_seen = 1'b0;
    for (int j = 0; j < 40; j++) begin
      tick();
      done_seen |= done;
    end
    check("inactive_no_done", 32'(done_seen), 32'd0);
    active = 1'b1;
    #1;
    check("inactive_still_idle", 32'(busy), 32'd0);
    cfg_read(ADDR_COUNT, d, ds);
    check("inactive_partial_count", d, 32'd1);

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 20; j++) tick();
    cfg_read(ADDR_COUNT, d, ds);
    check("pre_reset_count", d, 32'd3);
    rst_n = 1'b0;
    #2;
    check("midrun_reset_busy", 32'(busy), 32'd0);
    check("midrun_reset_done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    cfg_read(ADDR_COUNT, d, ds);
    check("midrun_reset_count", d, 32'd0);
    cfg_read(ADDR_RING, d, ds);
    check("midrun_reset_ring_mask", d, 32'hFFFF_FFFF);
    cfg_read(ADDR_GATE, d, ds);
    check("midrun_reset_gate", d, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
